// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit.
//   - MIPS exception codes that the MEM stage reports on excepttype_i.
//   - Default exception entry address.
//   - RUN/HOLD state encoding for the control FSM.
//   - Helper that says whether a nonzero code is one of the recognised ones.
package pipe_ctrl_pkg;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_INV  = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // True for the codes that have a defined redirect target.
    function automatic logic exc_known(input logic [31:0] code);
        return (code == EXC_INT)  || (code == EXC_SYS) ||
               (code == EXC_INV)  || (code == EXC_OV)  ||
               (code == EXC_TRAP) || (code == EXC_ERET);
    endfunction

endpackage

// File: rtl/pipe_ctrl_fsm_if.sv
// Signal bundle between the pipeline and its control unit.
//   excepttype_i    : exception code from MEM (0 = none)
//   cp0_epc_i       : EPC used as ERET target
//   stallreq_i      : per-stage stall requests (bit 0 = PC)
//   stall_o         : per-register hold enables (thermometer)
//   flush_o         : flush all pipeline registers
//   new_pc_o        : redirect target, valid while flush_o = 1
//   busy_o          : controller is holding a multi-cycle flush
//   stall_timeout_o : one-cycle watchdog pulse
//   unk_exc_o       : one-cycle pulse on an unrecognised nonzero code
//   stall_cnt_o     : consecutive stall cycle count
// Modport master is the controller side, slave is the pipeline side.
interface pipe_ctrl_fsm_if #(
    parameter int STAGES = 6,
    parameter int DW     = 32,
    parameter int CW     = 9
);
    logic [31:0]       excepttype_i;
    logic [DW-1:0]     cp0_epc_i;
    logic [STAGES-1:0] stallreq_i;
    logic [STAGES-1:0] stall_o;
    logic              flush_o;
    logic [DW-1:0]     new_pc_o;
    logic              busy_o;
    logic              stall_timeout_o;
    logic              unk_exc_o;
    logic [CW-1:0]     stall_cnt_o;

    modport master (
        input  excepttype_i, cp0_epc_i, stallreq_i,
        output stall_o, flush_o, new_pc_o, busy_o,
               stall_timeout_o, unk_exc_o, stall_cnt_o
    );

    modport slave (
        output excepttype_i, cp0_epc_i, stallreq_i,
        input  stall_o, flush_o, new_pc_o, busy_o,
               stall_timeout_o, unk_exc_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl_fsm_stall_thermo.sv
// Highest-set-bit to thermometer encoder for stall fabrics.
//   req    : per-stage stall requests
//   thermo : bit i set when any request at index >= i is set, so a stall
//            at stage k also freezes every earlier stage.
// Purely combinational.
module stall_thermo #(
    parameter int STAGES = 6
) (
    input  logic [STAGES-1:0] req,
    output logic [STAGES-1:0] thermo
);

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_thermo
            assign thermo[gi] = |req[STAGES-1:gi];
        end
    endgenerate

endmodule

// File: rtl/pipe_ctrl_fsm.sv
// Pipeline control unit for the MIPS core.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : pipe_ctrl_fsm_if.master (stall requests / exception in,
//         stall vector, flush, redirect PC and status out)
// In RUN an exception flushes immediately and redirects; with
// FLUSH_CYCLES > 1 the flush is held in HOLD using a latched target.
// Without an exception, stall requests become a thermometer stall vector
// and a watchdog counts consecutive stall cycles.
module pipe_ctrl_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int              STAGES        = 6,
    parameter int              DW            = 32,
    parameter logic [DW-1:0]   EXC_VECTOR    = DW'(EXC_VECTOR_DEFAULT),
    parameter int              FLUSH_CYCLES  = 1,
    parameter int              STALL_TIMEOUT = 256,
    parameter int              CW            = $clog2(STALL_TIMEOUT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    pipe_ctrl_fsm_if.master bus
);

    localparam int            HW        = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] STALL_MAX = CW'(STALL_TIMEOUT);

    state_t            state_reg, state_next;
    logic [HW-1:0]     hold_cnt_reg, hold_cnt_next;
    logic [DW-1:0]     tgt_reg, tgt_next;
    logic [CW-1:0]     stall_cnt_reg, stall_cnt_next;

    logic [STAGES-1:0] thermo;
    logic [DW-1:0]     exc_target;
    logic              exc_valid;

    logic [STAGES-1:0] stall_v;
    logic              flush_v;
    logic [DW-1:0]     new_pc_v;
    logic              busy_v;
    logic              timeout_v;
    logic              unk_v;
    logic [CW-1:0]     cnt_v;

    stall_thermo #(
        .STAGES (STAGES)
    ) u_thermo (
        .req    (bus.stallreq_i),
        .thermo (thermo)
    );

    assign exc_valid = (bus.excepttype_i != 32'd0);

    // ERET returns to the EPC sampled this cycle; everything else,
    // including unrecognised codes, enters the exception vector.
    always_comb begin
        exc_target = EXC_VECTOR;
        if (bus.excepttype_i == EXC_ERET) begin
            exc_target = bus.cp0_epc_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_RUN;
            hold_cnt_reg  <= '0;
            tgt_reg       <= '0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            hold_cnt_reg  <= hold_cnt_next;
            tgt_reg       <= tgt_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        hold_cnt_next  = hold_cnt_reg;
        tgt_next       = tgt_reg;
        stall_cnt_next = stall_cnt_reg;
        stall_v        = '0;
        flush_v        = 1'b0;
        new_pc_v       = '0;
        busy_v         = 1'b0;
        timeout_v      = 1'b0;
        unk_v          = 1'b0;
        cnt_v          = stall_cnt_reg;

        case (state_reg)
            ST_RUN: begin
                if (exc_valid) begin
                    // Exception beats any stall request in the same cycle.
                    flush_v        = 1'b1;
                    new_pc_v       = exc_target;
                    unk_v          = !exc_known(bus.excepttype_i);
                    tgt_next       = exc_target;
                    stall_cnt_next = '0;
                    if (FLUSH_CYCLES > 1) begin
                        state_next    = ST_HOLD;
                        hold_cnt_next = HW'(FLUSH_CYCLES - 1);
                    end
                end else begin
                    stall_v = thermo;
                    if (|thermo) begin
                        // Saturate so the pulse fires once per stall run.
                        if (stall_cnt_reg != STALL_MAX) begin
                            stall_cnt_next = stall_cnt_reg + CW'(1);
                            timeout_v      = (stall_cnt_reg == STALL_MAX - CW'(1));
                        end
                    end else begin
                        stall_cnt_next = '0;
                    end
                end
            end

            ST_HOLD: begin
                // Inputs are ignored here; a late exception is dropped and
                // upstream re-raises it once the pipeline refills.
                flush_v        = 1'b1;
                new_pc_v       = tgt_reg;
                busy_v         = 1'b1;
                stall_cnt_next = '0;
                hold_cnt_next  = hold_cnt_reg - HW'(1);
                if (hold_cnt_reg == HW'(1)) begin
                    state_next = ST_RUN;
                end
            end

            default: begin
                state_next = ST_RUN;
            end
        endcase

        // Outputs read zero for the whole reset cycle, including the count,
        // which otherwise still shows the pre-reset register value.
        if (rst) begin
            stall_v   = '0;
            flush_v   = 1'b0;
            new_pc_v  = '0;
            busy_v    = 1'b0;
            timeout_v = 1'b0;
            unk_v     = 1'b0;
            cnt_v     = '0;
        end
    end

    assign bus.stall_o         = stall_v;
    assign bus.flush_o         = flush_v;
    assign bus.new_pc_o        = new_pc_v;
    assign bus.busy_o          = busy_v;
    assign bus.stall_timeout_o = timeout_v;
    assign bus.unk_exc_o       = unk_v;
    assign bus.stall_cnt_o     = cnt_v;

endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
// Self-checking bench for pipe_ctrl_fsm.
// Two instances share clk/rst: dut_a (FLUSH_CYCLES=1) and dut_b
// (FLUSH_CYCLES=3), both with STALL_TIMEOUT=4. Each vector row drives one
// instance for one cycle; inputs change 1 time unit after posedge, outputs
// are compared at the following negedge. The cnt column is stall_cnt_o as
// seen during that cycle, i.e. the number of preceding consecutive stall
// cycles.
module tb_pipe_ctrl_fsm;

    localparam int STAGES = 6;
    localparam int DW     = 32;
    localparam int TMO    = 4;
    localparam int CW     = $clog2(TMO + 1);

    typedef struct {
        bit              sel;
        logic [31:0]     exc;
        logic [DW-1:0]   epc;
        logic [STAGES-1:0] req;
        logic [STAGES-1:0] stall;
        logic            flush;
        logic [DW-1:0]   pc;
        logic            busy;
        logic            tmo;
        logic            unk;
        logic [CW-1:0]   cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pipe_ctrl_fsm_if #(.STAGES(STAGES), .DW(DW), .CW(CW)) if_a ();
    pipe_ctrl_fsm_if #(.STAGES(STAGES), .DW(DW), .CW(CW)) if_b ();

    pipe_ctrl_fsm #(
        .STAGES(STAGES), .DW(DW), .EXC_VECTOR(32'h0000_0020),
        .FLUSH_CYCLES(1), .STALL_TIMEOUT(TMO), .CW(CW)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    pipe_ctrl_fsm #(
        .STAGES(STAGES), .DW(DW), .EXC_VECTOR(32'h0000_0020),
        .FLUSH_CYCLES(3), .STALL_TIMEOUT(TMO), .CW(CW)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    function automatic vec_t v(bit sel, logic [31:0] exc, logic [DW-1:0] epc,
                               logic [STAGES-1:0] req, logic [STAGES-1:0] stall,
                               logic flush, logic [DW-1:0] pc, logic busy,
                               logic tmo, logic unk, logic [CW-1:0] cnt);
        vec_t r;
        r.sel = sel; r.exc = exc; r.epc = epc; r.req = req; r.stall = stall;
        r.flush = flush; r.pc = pc; r.busy = busy; r.tmo = tmo; r.unk = unk;
        r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic [31:0] exc,
                         input logic [DW-1:0] epc, input logic [STAGES-1:0] req);
        if (sel == 1'b0) begin
            if_a.excepttype_i = exc; if_a.cp0_epc_i = epc; if_a.stallreq_i = req;
            if_b.excepttype_i = '0;  if_b.cp0_epc_i = '0;  if_b.stallreq_i = '0;
        end else begin
            if_b.excepttype_i = exc; if_b.cp0_epc_i = epc; if_b.stallreq_i = req;
            if_a.excepttype_i = '0;  if_a.cp0_epc_i = '0;  if_a.stallreq_i = '0;
        end
    endtask

    task automatic check_outputs(input bit sel, input int idx, input string tag,
                                 input logic [STAGES-1:0] stall, input logic flush,
                                 input logic [DW-1:0] pc, input logic busy,
                                 input logic tmo, input logic unk,
                                 input logic [CW-1:0] cnt);
        logic [STAGES-1:0] g_stall;
        logic              g_flush, g_busy, g_tmo, g_unk;
        logic [DW-1:0]     g_pc;
        logic [CW-1:0]     g_cnt;
        if (sel == 1'b0) begin
            g_stall = if_a.stall_o; g_flush = if_a.flush_o; g_pc = if_a.new_pc_o;
            g_busy = if_a.busy_o; g_tmo = if_a.stall_timeout_o;
            g_unk = if_a.unk_exc_o; g_cnt = if_a.stall_cnt_o;
        end else begin
            g_stall = if_b.stall_o; g_flush = if_b.flush_o; g_pc = if_b.new_pc_o;
            g_busy = if_b.busy_o; g_tmo = if_b.stall_timeout_o;
            g_unk = if_b.unk_exc_o; g_cnt = if_b.stall_cnt_o;
        end
        $display("%s %s step %0d: stall=%b flush=%b pc=%h busy=%b tmo=%b unk=%b cnt=%0d",
                 tag, sel ? "B" : "A", idx, g_stall, g_flush, g_pc, g_busy,
                 g_tmo, g_unk, g_cnt);
        chk({tag, " stall_o"},         idx, 32'(g_stall), 32'(stall));
        chk({tag, " flush_o"},         idx, 32'(g_flush), 32'(flush));
        chk({tag, " new_pc_o"},        idx, 32'(g_pc),    32'(pc));
        chk({tag, " busy_o"},          idx, 32'(g_busy),  32'(busy));
        chk({tag, " stall_timeout_o"}, idx, 32'(g_tmo),   32'(tmo));
        chk({tag, " unk_exc_o"},       idx, 32'(g_unk),   32'(unk));
        chk({tag, " stall_cnt_o"},     idx, 32'(g_cnt),   32'(cnt));
    endtask

    // One cycle of a hand-written sequence.
    task automatic step(input bit sel, input logic r, input logic [31:0] exc,
                        input logic [DW-1:0] epc, input logic [STAGES-1:0] req,
                        input int idx, input string tag,
                        input logic [STAGES-1:0] stall, input logic flush,
                        input logic [DW-1:0] pc, input logic busy,
                        input logic [CW-1:0] cnt);
        @(posedge clk);
        #1;
        rst = r;
        drive(sel, exc, epc, req);
        @(negedge clk);
        check_outputs(sel, idx, tag, stall, flush, pc, busy, 1'b0, 1'b0, cnt);
    endtask

    initial begin
        // --- vector table -------------------------------------------------
        // Stall on EX for 3 cycles, then release.
        vecs.push_back(v(0, 0, 0, 6'b001000, 6'b001111, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 6'b001000, 6'b001111, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 6'b001000, 6'b001111, 0, 0, 0, 0, 0, 2));
        vecs.push_back(v(0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0, 0, 0, 3));
        vecs.push_back(v(0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0, 0, 0, 0));
        // Exception beats a simultaneous ID stall; single-cycle flush.
        vecs.push_back(v(0, 32'h8, 0, 6'b000100, 6'b000000, 1, 32'h20, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0, 0, 0, 0));
        // Flush clears the stall counter.
        vecs.push_back(v(0, 0, 0, 6'b000010, 6'b000011, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 32'h1, 0, 6'b000010, 6'b000000, 1, 32'h20, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 6'b000010, 6'b000011, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0, 0, 0, 0));
        // Highest request wins.
        vecs.push_back(v(0, 0, 0, 6'b101010, 6'b111111, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 6'b000001, 6'b000001, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 6'b100000, 6'b111111, 0, 0, 0, 0, 0, 2));
        vecs.push_back(v(0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0, 0, 0, 3));
        vecs.push_back(v(0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0, 0, 0, 0));
        // Target mapping and unknown codes.
        vecs.push_back(v(0, 32'h7,   0, 0, 0, 1, 32'h20, 0, 0, 1, 0));
        vecs.push_back(v(0, 32'h100, 0, 0, 0, 1, 32'h20, 0, 0, 1, 0));
        vecs.push_back(v(0, 32'he, 32'h1234_5678, 0, 0, 1, 32'h1234_5678, 0, 0, 0, 0));
        vecs.push_back(v(0, 32'ha,   32'h1234_5678, 0, 0, 1, 32'h20, 0, 0, 0, 0));
        vecs.push_back(v(0, 32'hc,   0, 0, 0, 1, 32'h20, 0, 0, 0, 0));
        vecs.push_back(v(0, 32'hd,   0, 0, 0, 1, 32'h20, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Watchdog: pulse on the 4th stall cycle, then saturate at 4.
        vecs.push_back(v(0, 0, 0, 6'b000010, 6'b000011, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 6'b000010, 6'b000011, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 6'b000010, 6'b000011, 0, 0, 0, 0, 0, 2));
        vecs.push_back(v(0, 0, 0, 6'b000010, 6'b000011, 0, 0, 0, 1, 0, 3));
        vecs.push_back(v(0, 0, 0, 6'b000010, 6'b000011, 0, 0, 0, 0, 0, 4));
        vecs.push_back(v(0, 0, 0, 6'b000010, 6'b000011, 0, 0, 0, 0, 0, 4));
        vecs.push_back(v(0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0, 0, 0, 4));
        vecs.push_back(v(0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0, 0, 0, 0));
        // dut_b: ERET with 3-cycle flush; EPC changes after the first cycle
        // and stall requests during HOLD are ignored.
        vecs.push_back(v(1, 32'he, 32'hBFC0_0100, 0, 0, 1, 32'hBFC0_0100, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 6'b111111, 0, 1, 32'hBFC0_0100, 1, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 1, 32'hBFC0_0100, 1, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // dut_b: exceptions arriving in HOLD are dropped.
        vecs.push_back(v(1, 32'he, 32'hBFC0_0100, 0, 0, 1, 32'hBFC0_0100, 0, 0, 0, 0));
        vecs.push_back(v(1, 32'h1, 0, 0, 0, 1, 32'hBFC0_0100, 1, 0, 0, 0));
        vecs.push_back(v(1, 32'h7, 0, 0, 0, 1, 32'hBFC0_0100, 1, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // dut_b: HOLD clears the stall counter.
        vecs.push_back(v(1, 0, 0, 6'b000100, 6'b000111, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 6'b000100, 6'b000111, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(1, 32'h8, 0, 6'b000100, 0, 1, 32'h20, 0, 0, 0, 2));
        vecs.push_back(v(1, 0, 0, 6'b000100, 0, 1, 32'h20, 1, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 6'b000100, 0, 1, 32'h20, 1, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 6'b000100, 6'b000111, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // --- reset state (exception and stall asserted while in reset) ------
        drive(1'b0, 32'h8, 32'h0, 6'b001000);
        @(negedge clk);
        check_outputs(1'b0, 0, "reset", '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        drive(1'b0, 0, 0, 0);
        @(negedge clk);
        check_outputs(1'b0, 1, "reset", '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        rst = 1'b0;

        // --- table ---------------------------------------------------------
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].sel, vecs[i].exc, vecs[i].epc, vecs[i].req);
            @(negedge clk);
            check_outputs(vecs[i].sel, i, "vec", vecs[i].stall, vecs[i].flush,
                          vecs[i].pc, vecs[i].busy, vecs[i].tmo, vecs[i].unk,
                          vecs[i].cnt);
        end

        // --- reset mid-HOLD on dut_b aborts the flush ------------------------
        step(1'b1, 1'b0, 32'h8, 0, 0, 0, "rst_hold", 0, 1'b1, 32'h20, 1'b0, 0);
        step(1'b1, 1'b1, 0, 0, 0, 1, "rst_hold", 0, 1'b0, 0, 1'b0, 0);
        step(1'b1, 1'b0, 0, 0, 0, 2, "rst_hold", 0, 1'b0, 0, 1'b0, 0);

        // --- reset mid-stall on dut_a clears the watchdog count ---------------
        step(1'b0, 1'b0, 0, 0, 6'b001000, 0, "rst_stall", 6'b001111, 1'b0, 0, 1'b0, 0);
        step(1'b0, 1'b0, 0, 0, 6'b001000, 1, "rst_stall", 6'b001111, 1'b0, 0, 1'b0, 1);
        step(1'b0, 1'b1, 0, 0, 6'b001000, 2, "rst_stall", 6'b000000, 1'b0, 0, 1'b0, 0);
        step(1'b0, 1'b0, 0, 0, 6'b001000, 3, "rst_stall", 6'b001111, 1'b0, 0, 1'b0, 0);
        step(1'b0, 1'b0, 0, 0, 0, 4, "rst_stall", 6'b000000, 1'b0, 0, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
